// File: rtl/key_debounce.sv
// key_debounce: synchronise, decimate and debounce raw key pins.
// Emits clean levels, press/release pulses and a saturating press count.
module key_debounce #(
  parameter int          WIDTH        = 4,
  parameter logic [19:0] DECIMATION   = 20'd16,
  parameter logic [7:0]  STABLE_COUNT = 8'd4,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  input  logic             clr_count,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [15:0]      press_count,
  output logic             sample_tick
);

  localparam logic [WIDTH-1:0] IDLE = {WIDTH{ACTIVE_LOW}};
  localparam logic [19:0] DEC_LAST = DECIMATION - 20'd1;
  localparam logic [7:0]  ACCEPT   = STABLE_COUNT - 8'd1;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] same;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] state_nxt;
  logic [19:0]      div_cnt;
  logic [7:0]       cnt     [WIDTH];
  logic [7:0]       cnt_nxt [WIDTH];
  logic [4:0]       pop;
  logic [16:0]      sum;

  // Synchroniser idles at the released pin level so reset looks unpressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ IDLE;
  assign same = ~(norm ^ key_state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else if (div_cnt == DEC_LAST) begin
      div_cnt     <= '0;
      sample_tick <= 1'b1;
    end else begin
      div_cnt     <= div_cnt + 20'd1;
      sample_tick <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = key_state;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      unique case (1'b1)
        !sample_tick: ;
        sample_tick && same[i]:
          cnt_nxt[i] = '0;
        sample_tick && !same[i] && (cnt[i] == ACCEPT): begin
          state_nxt[i] = norm[i];
          cnt_nxt[i]   = '0;
        end
        default:
          cnt_nxt[i] = cnt[i] + 8'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_state <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      key_state <= state_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_d     <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      state_d     <= key_state;
      key_press   <= key_state & ~state_d;
      key_release <= ~key_state & state_d;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + 5'(key_press[i]);
    sum = {1'b0, press_count} + 17'(pop);
  end

  // A clear wins over same-cycle presses; sum[16] flags overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_count <= '0;
    end else if (clr_count) begin
      press_count <= '0;
    end else if (sum[16]) begin
      press_count <= 16'hFFFF;
    end else begin
      press_count <= sum[15:0];
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: vector table, directed corners and a random run
// checked against a sample-window reference model.
module tb_key_debounce;

  localparam int W  = 4;
  localparam int DA = 4;
  localparam int SA = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_raw = 4'hF;
  logic        clr_count = 1'b0;
  logic [3:0]  key_state, key_press, key_release;
  logic [15:0] press_count;
  logic        sample_tick;

  logic [15:0] b_raw = 16'hFFFF;
  logic        b_clr = 1'b0;
  logic [15:0] b_state, b_press, b_release, b_count;
  logic        b_tick;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .WIDTH(4), .DECIMATION(20'd4), .STABLE_COUNT(8'd3), .ACTIVE_LOW(1'b1)
  ) u_a (
    .clk(clk), .reset(reset), .key_raw(key_raw), .clr_count(clr_count),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .press_count(press_count), .sample_tick(sample_tick)
  );

  key_debounce #(
    .WIDTH(16), .DECIMATION(20'd1), .STABLE_COUNT(8'd1), .ACTIVE_LOW(1'b1)
  ) u_b (
    .clk(clk), .reset(reset), .key_raw(b_raw), .clr_count(b_clr),
    .key_state(b_state), .key_press(b_press), .key_release(b_release),
    .press_count(b_count), .sample_tick(b_tick)
  );

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference model: a key flips once its last SA samples all disagree.
  logic [3:0]  h1, h2, m_state, m_prev, m_press, m_rel;
  logic        m_tick;
  logic [15:0] m_cnt;
  int unsigned edge_n;
  logic        win [W][$];

  task automatic model_reset();
    h1 = 4'hF; h2 = 4'hF;
    m_state = '0; m_prev = '0; m_press = '0; m_rel = '0;
    m_tick = 1'b0; m_cnt = '0; edge_n = 0;
    for (int i = 0; i < W; i++) win[i].delete();
  endtask

  task automatic model_step();
    logic [3:0]  norm, nxt;
    logic [16:0] s;
    bit          all_diff;
    norm = h2 ^ 4'hF;
    edge_n++;
    s = 17'(m_cnt) + 17'($countones(m_press));
    nxt = m_state;
    if (m_tick) begin
      for (int i = 0; i < W; i++) begin
        win[i].push_back(norm[i]);
        if (win[i].size() > SA) void'(win[i].pop_front());
        if (win[i].size() == SA) begin
          all_diff = 1'b1;
          for (int j = 0; j < SA; j++)
            if (win[i][j] == m_state[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_state[i];
        end
      end
    end
    m_press = m_state & ~m_prev;
    m_rel   = ~m_state & m_prev;
    m_prev  = m_state;
    m_state = nxt;
    m_cnt   = clr_count ? 16'h0 : (s > 17'hFFFF ? 16'hFFFF : s[15:0]);
    m_tick  = (edge_n % DA == 0);
    h2 = h1;
    h1 = key_raw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("model key_state", key_state, m_state);
        check("model key_press", key_press, m_press);
        check("model key_release", key_release, m_rel);
        check("model press_count", press_count, m_cnt);
        check("model sample_tick", sample_tick, m_tick);
      end
    end
  end

  typedef struct {
    logic [3:0]  raw;
    logic        clr;
    int          cyc;
    logic [3:0]  exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [10];

  int n, bad, ticks, pulses;

  initial begin
    vt[0] = '{4'hF, 1'b0, 40, 4'h0, 16'd0};
    vt[1] = '{4'hE, 1'b0, 30, 4'h1, 16'd1};
    vt[2] = '{4'hF, 1'b0, 30, 4'h0, 16'd1};
    vt[3] = '{4'h5, 1'b0, 30, 4'hA, 16'd3};
    vt[4] = '{4'h0, 1'b0, 30, 4'hF, 16'd5};
    vt[5] = '{4'hF, 1'b0, 30, 4'h0, 16'd5};
    vt[6] = '{4'hF, 1'b1, 3,  4'h0, 16'd0};
    vt[7] = '{4'h7, 1'b0, 30, 4'h8, 16'd1};
    vt[8] = '{4'hF, 1'b0, 30, 4'h0, 16'd1};
    vt[9] = '{4'hF, 1'b1, 3,  4'h0, 16'd0};

    // Reset without any clock edge
    #1 reset = 1'b0;
    #2;
    check("reset key_state", key_state, 4'h0);
    check("reset key_press", key_press, 4'h0);
    check("reset key_release", key_release, 4'h0);
    check("reset press_count", press_count, 16'h0);
    check("reset sample_tick", sample_tick, 1'b0);
    check("reset b_state", b_state, 16'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (key_state != 0 || key_press != 0 || key_release != 0) bad++;
    end
    check("idle after reset", bad, 0);

    // Vector table
    for (int v = 0; v < 10; v++) begin
      key_raw = vt[v].raw;
      clr_count = vt[v].clr;
      @(negedge clk);
      clr_count = 1'b0;
      repeat (vt[v].cyc - 1) @(negedge clk);
      check($sformatf("vec%0d key_state", v), key_state, vt[v].exp_state);
      check($sformatf("vec%0d press_count", v), press_count, vt[v].exp_cnt);
    end

    // Clean press on key 0 and its latency window
    key_raw = 4'hE;
    n = 0;
    while (key_state[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("press latency 11..15", (n >= 11 && n <= 15), 1'b1);
    check("press not yet", key_press, 4'h0);
    @(negedge clk);
    check("press pulse", key_press, 4'h1);
    @(negedge clk);
    check("press pulse end", key_press, 4'h0);
    check("count after press", press_count, 16'd1);
    key_raw = 4'hF;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (key_release[0]) pulses++;
    end
    check("release pulses", pulses, 1);
    check("count after release", press_count, 16'd1);

    // Bounce on key 1
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) key_raw[1] = ~key_raw[1];
      @(negedge clk);
      if (key_state[1] || key_press != 0 || press_count != 16'd1) bad++;
    end
    key_raw = 4'hF;
    repeat (30) begin
      @(negedge clk);
      if (key_state[1] || key_press != 0 || press_count != 16'd1) bad++;
    end
    check("bounce rejected", bad, 0);

    // Simultaneous presses
    key_raw = 4'h0;
    n = 0;
    while (key_press == 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("simul press", key_press, 4'hF);
    check("simul count before", press_count, 16'd1);
    @(negedge clk);
    check("simul count after", press_count, 16'd5);
    key_raw = 4'hF;
    repeat (30) @(negedge clk);
    key_raw = 4'h0;
    n = 0;
    while (key_press == 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("simul press 2", key_press, 4'hF);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    check("clr beats press", press_count, 16'd0);
    key_raw = 4'hF;
    repeat (30) @(negedge clk);

    // Reset in the middle of debouncing key 2
    key_raw = 4'h7;
    repeat (30) @(negedge clk);
    check("key3 held", key_state, 4'h8);
    key_raw = 4'h3;
    repeat (2) @(negedge clk);
    ticks = 0;
    n = 0;
    while (ticks < 2 && n < 50) begin
      @(negedge clk);
      n++;
      if (sample_tick) ticks++;
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset key_state", key_state, 4'h0);
    check("midreset press_count", press_count, 16'd0);
    check("midreset sample_tick", sample_tick, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ticks = 0;
    n = 0;
    while (ticks < 2 && n < 50) begin
      @(negedge clk);
      n++;
      if (sample_tick) ticks++;
    end
    @(negedge clk);
    check("after 2 ticks", key_state[2], 1'b0);
    n = 0;
    while (ticks < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (sample_tick) ticks++;
    end
    @(negedge clk);
    check("after 3 ticks", key_state[2], 1'b1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (key_press[2]) pulses++;
    end
    check("fresh press pulses", pulses, 1);
    key_raw = 4'hF;
    repeat (30) @(negedge clk);

    // Random run against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 9) == 0) key_raw[i] = ~key_raw[i];
      clr_count = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    clr_count = 1'b0;
    key_raw = 4'hF;
    repeat (30) @(negedge clk);

    // Saturation on the fast 16-key instance
    for (int r = 0; r < 4095; r++) begin
      b_raw = 16'h0000;
      repeat (4) @(negedge clk);
      b_raw = 16'hFFFF;
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("sat 65520", b_count, 16'd65520);
    b_raw = 16'hC000;
    repeat (4) @(negedge clk);
    b_raw = 16'hFFFF;
    repeat (6) @(negedge clk);
    check("sat FFFE", b_count, 16'hFFFE);
    b_raw = 16'hFFFC;
    repeat (4) @(negedge clk);
    b_raw = 16'hFFFF;
    repeat (6) @(negedge clk);
    check("sat FFFF", b_count, 16'hFFFF);
    b_raw = 16'h0000;
    repeat (4) @(negedge clk);
    b_raw = 16'hFFFF;
    repeat (6) @(negedge clk);
    check("sat hold", b_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
